// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Two-requester access bus between requesters and mem_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int M = 32,
  parameter int N = 10
);
  logic         req0;
  logic         req1;
  logic         we0;
  logic         we1;
  logic [N-1:0] addr0;
  logic [N-1:0] addr1;
  logic [M-1:0] wdata0;
  logic [M-1:0] wdata1;
  logic         gnt0;
  logic         gnt1;
  logic         rvalid0;
  logic         rvalid1;
  logic [M-1:0] rdata0;
  logic [M-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter and zero-initialiser for a shared 1-port RAM.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int M = 32,
  parameter int N = 10
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear_start,
  output logic          busy,
  mem_arbiter_if.slave  bus,
  output logic [N-1:0]  mem_address,
  output logic [M-1:0]  mem_memin,
  output logic          mem_we,
  input  logic [M-1:0]  mem_memout
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_ARB   = 1'b1
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_cnt, w_cnt_nxt;
  logic         r_last, w_last_nxt;
  logic         r_acc_we, w_acc_we_nxt;
  logic [N-1:0] r_addr, w_addr_nxt;
  logic [M-1:0] r_memin, w_memin_nxt;
  logic         r_we, w_we_nxt;
  logic         r_gnt0, w_gnt0_nxt;
  logic         r_gnt1, w_gnt1_nxt;
  logic         r_rvalid0, w_rvalid0_nxt;
  logic         r_rvalid1, w_rvalid1_nxt;
  logic [M-1:0] r_rdata0, w_rdata0_nxt;
  logic [M-1:0] r_rdata1, w_rdata1_nxt;
  logic         r_busy;

  // A requester already in its grant cycle is masked so it is not served twice.
  logic w_elig0, w_elig1, w_sel0, w_sel1;
  assign w_elig0 = bus.req0 & ~r_gnt0;
  assign w_elig1 = bus.req1 & ~r_gnt1;
  assign w_sel0  = w_elig0 & (~w_elig1 | r_last);
  assign w_sel1  = w_elig1 & (~w_elig0 | ~r_last);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_last_nxt    = r_last;
    w_acc_we_nxt  = r_acc_we;
    w_addr_nxt    = r_addr;
    w_memin_nxt   = r_memin;
    w_we_nxt      = 1'b0;
    w_gnt0_nxt    = 1'b0;
    w_gnt1_nxt    = 1'b0;
    w_rvalid0_nxt = 1'b0;
    w_rvalid1_nxt = 1'b0;
    w_rdata0_nxt  = r_rdata0;
    w_rdata1_nxt  = r_rdata1;

    // The access in its grant cycle always completes, whatever the state does.
    if (r_gnt0 && !r_acc_we) begin
      w_rdata0_nxt  = mem_memout;
      w_rvalid0_nxt = 1'b1;
    end
    if (r_gnt1 && !r_acc_we) begin
      w_rdata1_nxt  = mem_memout;
      w_rvalid1_nxt = 1'b1;
    end

    case (r_state)
      S_CLEAR: begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = r_cnt;
        w_memin_nxt = '0;
        w_cnt_nxt   = r_cnt + N'(1);
        if (&r_cnt) begin
          w_state_nxt = S_ARB;
          w_cnt_nxt   = '0;
        end
      end
      S_ARB: begin
        if (clear_start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end else if (w_sel0) begin
          w_addr_nxt   = bus.addr0;
          w_memin_nxt  = bus.wdata0;
          w_we_nxt     = bus.we0;
          w_acc_we_nxt = bus.we0;
          w_gnt0_nxt   = 1'b1;
          w_last_nxt   = 1'b0;
        end else if (w_sel1) begin
          w_addr_nxt   = bus.addr1;
          w_memin_nxt  = bus.wdata1;
          w_we_nxt     = bus.we1;
          w_acc_we_nxt = bus.we1;
          w_gnt1_nxt   = 1'b1;
          w_last_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_CLEAR;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_acc_we  <= 1'b0;
      r_addr    <= '0;
      r_memin   <= '0;
      r_we      <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_acc_we  <= w_acc_we_nxt;
      r_addr    <= w_addr_nxt;
      r_memin   <= w_memin_nxt;
      r_we      <= w_we_nxt;
      r_gnt0    <= w_gnt0_nxt;
      r_gnt1    <= w_gnt1_nxt;
      r_rvalid0 <= w_rvalid0_nxt;
      r_rvalid1 <= w_rvalid1_nxt;
      r_rdata0  <= w_rdata0_nxt;
      r_rdata1  <= w_rdata1_nxt;
      r_busy    <= (w_state_nxt == S_CLEAR);
    end
  end

  assign busy        = r_busy;
  assign mem_address = r_addr;
  assign mem_memin   = r_memin;
  assign mem_we      = r_we;
  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.rvalid0 = r_rvalid0;
  assign bus.rvalid1 = r_rvalid1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed bench for mem_arbiter with a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int M     = 32;
  localparam int N     = 4;
  localparam int DEPTH = 16;

  logic         clock       = 1'b0;
  logic         reset_n     = 1'b0;
  logic         clear_start = 1'b0;
  logic         busy;
  logic [N-1:0] mem_address;
  logic [M-1:0] mem_memin;
  logic [M-1:0] mem_memout;
  logic         mem_we;

  mem_arbiter_if #(.M(M), .N(N)) bus ();

  mem_arbiter #(.M(M), .N(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_start (clear_start),
    .busy        (busy),
    .bus         (bus.slave),
    .mem_address (mem_address),
    .mem_memin   (mem_memin),
    .mem_we      (mem_we),
    .mem_memout  (mem_memout)
  );

  always #5 clock = ~clock;

  // The shared memory itself: synchronous write, asynchronous read.
  logic [M-1:0] mem [DEPTH];
  always @(posedge clock) if (mem_we) mem[mem_address] <= mem_memin;
  assign mem_memout = mem[mem_address];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_sweep = 0;      // next sweep index, -1 when arbitrating
  bit           m_last  = 1'b1;
  logic         x_busy  = 1'b1;
  logic [1:0]   x_gnt   = 2'b00;
  logic [1:0]   x_rv    = 2'b00;
  logic         x_we    = 1'b0;
  logic [N-1:0] x_addr  = '0;
  logic [M-1:0] x_memin = '0;
  logic [M-1:0] x_rd0   = '0;
  logic [M-1:0] x_rd1   = '0;
  logic         p_we    = 1'b0;
  logic [N-1:0] p_addr  = '0;
  logic [M-1:0] p_data  = '0;
  logic [M-1:0] ref_mem [DEPTH];

  function automatic int pick(input logic e0, input logic e1, input bit last);
    if (e0 && e1) return last ? 0 : 1;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_sweep <= 0;  m_last <= 1'b1; x_busy <= 1'b1;
      x_gnt <= 2'b00; x_rv <= 2'b00; x_we <= 1'b0;
      x_addr <= '0;  x_memin <= '0; x_rd0 <= '0; x_rd1 <= '0;
    end else begin
      x_rv  <= 2'b00;
      x_gnt <= 2'b00;
      x_we  <= 1'b0;
      if (x_gnt != 2'b00) begin
        if (p_we) ref_mem[p_addr] <= p_data;
        else if (x_gnt[0]) begin x_rd0 <= ref_mem[p_addr]; x_rv <= 2'b01; end
        else begin x_rd1 <= ref_mem[p_addr]; x_rv <= 2'b10; end
      end
      if (m_sweep >= 0) begin
        x_we    <= 1'b1;
        x_addr  <= m_sweep[N-1:0];
        x_memin <= '0;
        ref_mem[m_sweep] <= '0;
        m_sweep <= (m_sweep == DEPTH-1) ? -1 : m_sweep + 1;
        x_busy  <= (m_sweep != DEPTH-1);
      end else if (clear_start) begin
        m_sweep <= 0;
        x_busy  <= 1'b1;
      end else begin
        case (pick(bus.req0 & ~x_gnt[0], bus.req1 & ~x_gnt[1], m_last))
          0: begin
            x_gnt <= 2'b01; x_we <= bus.we0; x_addr <= bus.addr0; x_memin <= bus.wdata0;
            m_last <= 1'b0; p_we <= bus.we0; p_addr <= bus.addr0; p_data <= bus.wdata0;
          end
          1: begin
            x_gnt <= 2'b10; x_we <= bus.we1; x_addr <= bus.addr1; x_memin <= bus.wdata1;
            m_last <= 1'b1; p_we <= bus.we1; p_addr <= bus.addr1; p_data <= bus.wdata1;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    chk("busy",        busy,         x_busy);
    chk("gnt0",        bus.gnt0,     x_gnt[0]);
    chk("gnt1",        bus.gnt1,     x_gnt[1]);
    chk("rvalid0",     bus.rvalid0,  x_rv[0]);
    chk("rvalid1",     bus.rvalid1,  x_rv[1]);
    chk("rdata0",      bus.rdata0,   x_rd0);
    chk("rdata1",      bus.rdata1,   x_rd1);
    chk("mem_we",      mem_we,       x_we);
    chk("mem_address", mem_address,  x_addr);
    chk("mem_memin",   mem_memin,    x_memin);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents a request and returns in its grant cycle with req dropped.
  task automatic access(input int id, input logic w, input logic [N-1:0] a,
                        input logic [M-1:0] d, output int lat);
    if (id == 0) begin bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    else         begin bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
    lat = 0;
    do begin
      step();
      lat++;
    end while (!((id == 0) ? bus.gnt0 : bus.gnt1) && lat < 100);
    chk("grant_timeout", M'(lat >= 100), '0);
    if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic read(input int id, input logic [N-1:0] a, output logic [M-1:0] rd, output int lat);
    access(id, 1'b0, a, '0, lat);
    step();
    chk("read_rvalid", (id == 0) ? bus.rvalid0 : bus.rvalid1, 1);
    rd = (id == 0) ? bus.rdata0 : bus.rdata1;
  endtask

  initial begin
    int lat, k, nb, nrv;
    logic [M-1:0] rd;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    // Reset state
    step();
    chk("rst_busy", busy, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
    chk("rst_addr", mem_address, 0);
    step(); step();
    reset_n = 1'b1;

    // Post-reset sweep: 16 writes of zero to 0..15
    k = 0;
    nb = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_we) begin
        chk("sweep_addr", mem_address, k);
        chk("sweep_memin", mem_memin, 0);
        k++;
      end
      if (busy) nb++;
    end
    chk("sweep_len", k, 16);
    chk("busy_len", nb, 16);

    // Every address reads back zero
    for (int a = 0; a < DEPTH; a++) begin
      read(0, a[N-1:0], rd, lat);
      chk("zero_read", rd, 0);
    end

    // Write then back-to-back read by requester 0
    access(0, 1'b1, 4'd5, 32'hDEADBEEF, lat);
    chk("wr_lat", lat, 1);
    read(0, 4'd5, rd, lat);
    chk("rd_lat_masked", lat, 2);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);
    chk("rdata1_untouched", bus.rdata1, 0);

    read(1, 4'd5, rd, lat);
    chk("rd1_deadbeef", rd, 32'hDEADBEEF);

    // Both requesting continuously: strict alternation starting with 0
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd5;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("alt_gnt0", bus.gnt0, (i % 2 == 0) ? 1 : 0);
      chk("alt_gnt1", bus.gnt1, (i % 2 == 1) ? 1 : 0);
      if (i == 6) bus.req0 = 0;
      if (i == 7) bus.req1 = 0;
    end
    step();
    chk("alt_last_rv1", bus.rvalid1, 1);
    chk("alt_rd1", bus.rdata1, 0);
    chk("alt_rd0", bus.rdata0, 32'hDEADBEEF);

    // Write by 1, read by 0 accepted at the edge ending the write's access cycle
    access(1, 1'b1, 4'd3, 32'h12345678, lat);
    read(0, 4'd3, rd, lat);
    chk("fwd_lat", lat, 1);
    chk("fwd_rd", rd, 32'h12345678);

    // clear_start collides with a pending req0 while a write is in its grant cycle
    access(1, 1'b1, 4'd2, 32'hA5A5A5A5, lat);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd2;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    chk("clr_busy", busy, 1);
    chk("clr_no_gnt", bus.gnt0, 0);
    chk("clr_we", mem_we, 0);
    chk("clr_write_landed", mem[2], 32'hA5A5A5A5);
    lat = 0;
    while (!bus.gnt0 && lat < 100) begin
      step();
      lat++;
    end
    chk("clr_gnt_wait", lat, 17);
    bus.req0 = 0;
    step();
    chk("clr_rv0", bus.rvalid0, 1);
    chk("clr_rd0", bus.rdata0, 0);

    // Reset during a requester 1 write grant cycle
    access(1, 1'b1, 4'd7, 32'h00000055, lat);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_gnt1", bus.gnt1, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_busy", busy, 1);
    step(); step();
    reset_n = 1'b1;
    k = 0;
    nrv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_we) k++;
      if (bus.rvalid0 || bus.rvalid1) nrv++;
    end
    chk("arst_sweep_len", k, 16);
    chk("arst_no_rvalid", nrv, 0);
    chk("arst_mem7_swept", mem[7], 0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
